iq_framer_axil_regs: RTL and testbench

AXI4-Lite responder (slave) register bank that configures and monitors the IQ framer datapath. It sits between the processor-side AXI4-Lite interconnect (S00_AXI) and the framer core. It accepts single-beat register writes and reads, drives the framer control outputs, and counts completed frames reported by the core.

---
 rtl/iq_framer_axil_regs.sv | 163 ++++++++++++++++
 tb/tb_iq_framer_axil_regs.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_framer_axil_regs.sv
// AXI4-Lite register bank for the IQ framer: CTRL, LEN, a saturating frame COUNT and SCRATCH.
// Write address and data are buffered independently and commit together into a single write response.
module iq_framer_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              frame_enable,
    output logic [15:0]                       frame_len,
    input  logic                              frame_done
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_LEN     = 2'd1;
    localparam logic [1:0] IDX_COUNT   = 2'd2;
    localparam logic [1:0] IDX_SCRATCH = 2'd3;

    logic        aw_held;
    logic [1:0]  aw_idx_q;
    logic        w_held;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] count_q;
    logic [31:0] scratch_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic        clear_count;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_bmask;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = !aw_held && !s00_axi_bvalid;
    assign s00_axi_wready  = !w_held && !s00_axi_bvalid;
    assign s00_axi_arready = !s00_axi_rvalid;
    assign s00_axi_rresp   = RESP_OKAY;

    // Each half of a write may come from its holding register or from this cycle's handshake.
    always_comb begin
        aw_hs       = s00_axi_awvalid && s00_axi_awready;
        w_hs        = s00_axi_wvalid && s00_axi_wready;
        ar_hs       = s00_axi_arvalid && s00_axi_arready;
        wr_idx      = aw_held ? aw_idx_q : s00_axi_awaddr[3:2];
        wr_data     = w_held ? w_data_q : s00_axi_wdata;
        wr_strb     = w_held ? w_strb_q : s00_axi_wstrb;
        commit      = (aw_held || aw_hs) && (w_held || w_hs);
        clear_count = commit && (wr_idx == IDX_CTRL) && wr_strb[0] && wr_data[1];
        for (int i = 0; i < 4; i++) begin
            wr_bmask[i*8 +: 8] = {8{wr_strb[i]}};
        end
    end

    always_comb begin
        rd_word = '0;
        case (s00_axi_araddr[3:2])
            IDX_CTRL:    rd_word = {31'd0, frame_enable};
            IDX_LEN:     rd_word = {16'd0, frame_len};
            IDX_COUNT:   rd_word = count_q;
            IDX_SCRATCH: rd_word = scratch_q;
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held        <= 1'b0;
            aw_idx_q       <= '0;
            w_held         <= 1'b0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
        end else if (commit) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= (wr_idx == IDX_COUNT) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end
            if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // COUNT is read-only over the bus, so a committed write to it changes nothing here.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            frame_enable <= 1'b0;
            frame_len    <= 16'h0100;
            scratch_q    <= '0;
        end else if (commit) begin
            case (wr_idx)
                IDX_CTRL: begin
                    if (wr_strb[0]) begin
                        frame_enable <= wr_data[0];
                    end
                end
                IDX_LEN:     frame_len <= (frame_len & ~wr_bmask[15:0]) | (wr_data[15:0] & wr_bmask[15:0]);
                IDX_SCRATCH: scratch_q <= (scratch_q & ~wr_bmask) | (wr_data & wr_bmask);
                default: ;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset || clear_count) begin
            count_q <= '0;
        end else if (frame_done && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
        end else if (ar_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_word;
        end else if (s00_axi_rvalid && s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_framer_axil_regs.sv
// Self-checking bench for iq_framer_axil_regs: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized concurrent read/write/frame phase.
module tb_iq_framer_axil_regs;

    logic        s00_axi_aclk;
    logic        s00_axi_areset;
    logic [3:0]  s00_axi_awaddr;
    logic [2:0]  s00_axi_awprot;
    logic        s00_axi_awvalid;
    logic        s00_axi_awready;
    logic [31:0] s00_axi_wdata;
    logic [3:0]  s00_axi_wstrb;
    logic        s00_axi_wvalid;
    logic        s00_axi_wready;
    logic [1:0]  s00_axi_bresp;
    logic        s00_axi_bvalid;
    logic        s00_axi_bready;
    logic [3:0]  s00_axi_araddr;
    logic [2:0]  s00_axi_arprot;
    logic        s00_axi_arvalid;
    logic        s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic [1:0]  s00_axi_rresp;
    logic        s00_axi_rvalid;
    logic        s00_axi_rready;
    logic        frame_enable;
    logic [15:0] frame_len;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    iq_framer_axil_regs dut (
        .s00_axi_aclk   (s00_axi_aclk),
        .s00_axi_areset (s00_axi_areset),
        .s00_axi_awaddr (s00_axi_awaddr),
        .s00_axi_awprot (s00_axi_awprot),
        .s00_axi_awvalid(s00_axi_awvalid),
        .s00_axi_awready(s00_axi_awready),
        .s00_axi_wdata  (s00_axi_wdata),
        .s00_axi_wstrb  (s00_axi_wstrb),
        .s00_axi_wvalid (s00_axi_wvalid),
        .s00_axi_wready (s00_axi_wready),
        .s00_axi_bresp  (s00_axi_bresp),
        .s00_axi_bvalid (s00_axi_bvalid),
        .s00_axi_bready (s00_axi_bready),
        .s00_axi_araddr (s00_axi_araddr),
        .s00_axi_arprot (s00_axi_arprot),
        .s00_axi_arvalid(s00_axi_arvalid),
        .s00_axi_arready(s00_axi_arready),
        .s00_axi_rdata  (s00_axi_rdata),
        .s00_axi_rresp  (s00_axi_rresp),
        .s00_axi_rvalid (s00_axi_rvalid),
        .s00_axi_rready (s00_axi_rready),
        .frame_enable   (frame_enable),
        .frame_len      (frame_len),
        .frame_done     (frame_done)
    );

    initial s00_axi_aclk = 1'b0;
    always #5 s00_axi_aclk = ~s00_axi_aclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: register file with per-register writable masks, AW/W queues, one B and one R slot.
    logic [1:0]  aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] m_regs[4];
    logic        m_bvalid = 1'b0;
    logic [1:0]  m_bresp  = 2'b00;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = 32'd0;
    logic        model_on = 1'b0;

    function automatic logic [31:0] writable(input logic [1:0] idx);
        case (idx)
            2'd0:    return 32'h0000_0001;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h0000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(posedge s00_axi_aclk) begin : ref_model
        logic        exp_aw;
        logic        exp_w;
        logic [1:0]  idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] bm;
        logic [31:0] keep;
        logic        clr;
        logic [31:0] snap[4];
        if (s00_axi_areset) begin
            aw_q.delete();
            w_q.delete();
            m_bvalid  = 1'b0;
            m_bresp   = 2'b00;
            m_rvalid  = 1'b0;
            m_rdata   = 32'd0;
            m_regs[0] = 32'd0;
            m_regs[1] = 32'h0000_0100;
            m_regs[2] = 32'd0;
            m_regs[3] = 32'd0;
            model_on  = 1'b1;
        end else if (model_on) begin
            snap   = m_regs;
            exp_aw = (aw_q.size() == 0) && !m_bvalid;
            exp_w  = (w_q.size() == 0) && !m_bvalid;
            if (s00_axi_arvalid && !m_rvalid) begin
                m_rvalid = 1'b1;
                m_rdata  = snap[s00_axi_araddr[3:2]];
            end else if (m_rvalid && s00_axi_rready) begin
                m_rvalid = 1'b0;
            end
            if (m_bvalid && s00_axi_bready) m_bvalid = 1'b0;
            if (s00_axi_awvalid && exp_aw) aw_q.push_back(s00_axi_awaddr[3:2]);
            if (s00_axi_wvalid && exp_w) w_q.push_back({s00_axi_wstrb, s00_axi_wdata});
            clr = 1'b0;
            if (aw_q.size() != 0 && w_q.size() != 0) begin
                idx    = aw_q.pop_front();
                {s, d} = w_q.pop_front();
                for (int b = 0; b < 4; b++) bm[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
                keep        = bm & writable(idx);
                m_regs[idx] = (m_regs[idx] & ~keep) | (d & keep);
                m_bresp     = (idx == 2'd2) ? 2'b10 : 2'b00;
                m_bvalid    = 1'b1;
                clr         = (idx == 2'd0) && s[0] && d[1];
            end
            if (clr) m_regs[2] = 32'd0;
            else if (frame_done && m_regs[2] != 32'hFFFF_FFFF) m_regs[2] = m_regs[2] + 32'd1;
        end
    end

    always @(negedge s00_axi_aclk) begin
        if (model_on) begin
            checkOutput("awready", 32'(s00_axi_awready), 32'((aw_q.size() == 0) && !m_bvalid));
            checkOutput("wready", 32'(s00_axi_wready), 32'((w_q.size() == 0) && !m_bvalid));
            checkOutput("arready", 32'(s00_axi_arready), 32'(!m_rvalid));
            checkOutput("bvalid", 32'(s00_axi_bvalid), 32'(m_bvalid));
            checkOutput("bresp", 32'(s00_axi_bresp), 32'(m_bresp));
            checkOutput("rvalid", 32'(s00_axi_rvalid), 32'(m_rvalid));
            checkOutput("rdata", s00_axi_rdata, m_rdata);
            checkOutput("rresp", 32'(s00_axi_rresp), 32'd0);
            checkOutput("frame_enable", 32'(frame_enable), 32'(m_regs[0][0]));
            checkOutput("frame_len", 32'(frame_len), {16'd0, m_regs[1][15:0]});
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input int fd_cyc,
                             output logic [1:0] resp, output int b_first);
        int   cyc = 0;
        int   b_wait = 0;
        bit   aw_done = 0;
        bit   w_done = 0;
        bit   b_done = 0;
        logic awr, wr, bv;
        b_first = -1;
        resp    = 2'bxx;
        while (!b_done && cyc < 200) begin
            @(negedge s00_axi_aclk);
            #1;
            s00_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s00_axi_awaddr  = addr;
            s00_axi_wvalid  = !w_done && (cyc >= w_dly);
            s00_axi_wdata   = data;
            s00_axi_wstrb   = strb;
            if (fd_cyc >= 0) frame_done = (cyc == fd_cyc);
            awr = s00_axi_awready;
            wr  = s00_axi_wready;
            bv  = s00_axi_bvalid;
            if (bv && b_first < 0) b_first = cyc;
            s00_axi_bready = bv && (b_wait >= b_dly);
            if (s00_axi_bready) resp = s00_axi_bresp;
            @(posedge s00_axi_aclk);
            if (s00_axi_awvalid && awr) aw_done = 1;
            if (s00_axi_wvalid && wr) w_done = 1;
            if (bv) begin
                if (s00_axi_bready) b_done = 1;
                else b_wait++;
            end
            cyc++;
        end
        if (fd_cyc >= 0) frame_done = 1'b0;
        checkOutput("write_completed", 32'(b_done), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly,
                            output logic [31:0] data, output int ar_cyc, output int r_first);
        int   cyc = 0;
        int   r_wait = 0;
        bit   ar_done = 0;
        bit   r_done = 0;
        logic arr, rv;
        ar_cyc  = -1;
        r_first = -1;
        data    = 32'hDEAD_DEAD;
        while (!r_done && cyc < 100) begin
            @(negedge s00_axi_aclk);
            #1;
            s00_axi_arvalid = !ar_done;
            s00_axi_araddr  = addr;
            arr = s00_axi_arready;
            rv  = s00_axi_rvalid;
            if (rv && r_first < 0) r_first = cyc;
            s00_axi_rready = rv && (r_wait >= r_dly);
            if (rv) data = s00_axi_rdata;
            @(posedge s00_axi_aclk);
            if (s00_axi_arvalid && arr) begin
                ar_done = 1;
                ar_cyc  = cyc;
            end
            if (rv) begin
                if (s00_axi_rready) r_done = 1;
                else r_wait++;
            end
            cyc++;
        end
        checkOutput("read_completed", 32'(r_done), 32'd1);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge s00_axi_aclk);
            #1;
            frame_done = 1'b1;
            @(negedge s00_axi_aclk);
            #1;
            frame_done = 1'b0;
        end
    endtask

    task automatic applyStimulus();
        logic [1:0]  resp;
        logic [31:0] data;
        int          bf, ac, rf;
        logic [3:0]  r_addr [4];
        logic [31:0] r_exp  [4];
        logic [31:0] wr_val [4];
        logic [1:0]  wr_rsp [4];
        bit          stop;

        // LEN read with rready held off, then a back-to-back read straight after the R handshake.
        axi_read(4'h4, 3, data, ac, rf);
        checkOutput("len_reset_read", data, 32'h0000_0100);
        checkOutput("first_ar_cycle", 32'(ac), 32'd0);
        checkOutput("first_r_cycle", 32'(rf), 32'd1);
        axi_read(4'h4, 0, data, ac, rf);
        checkOutput("b2b_ar_cycle", 32'(ac), 32'd0);
        checkOutput("b2b_read", data, 32'h0000_0100);

        r_addr = '{4'h0, 4'h4, 4'h8, 4'hC};
        wr_val = '{32'h1, 32'h2, 32'h3, 32'h4};
        wr_rsp = '{2'b00, 2'b00, 2'b10, 2'b00};
        r_exp  = '{32'h1, 32'h2, 32'h0, 32'h4};
        for (int i = 0; i < 4; i++) begin
            axi_write(r_addr[i], wr_val[i], 4'hF, 0, 0, 0, -1, resp, bf);
            checkOutput($sformatf("map_bresp_%0d", i), 32'(resp), 32'(wr_rsp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(r_addr[i], 0, data, ac, rf);
            checkOutput($sformatf("map_read_%0d", i), data, r_exp[i]);
        end
        checkOutput("map_frame_enable", 32'(frame_enable), 32'd1);
        checkOutput("map_frame_len", 32'(frame_len), 32'h0002);

        axi_write(4'hC, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, -1, resp, bf);
        axi_write(4'hC, 32'h00FF_0000, 4'b0100, 0, 0, 0, -1, resp, bf);
        checkOutput("strb_bresp", 32'(resp), 32'd0);
        axi_read(4'hC, 0, data, ac, rf);
        checkOutput("strb_scratch", data, 32'hA5FF_A5A5);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, -1, resp, bf);
        checkOutput("nostrb_bresp", 32'(resp), 32'd0);
        axi_read(4'hC, 0, data, ac, rf);
        checkOutput("nostrb_scratch", data, 32'hA5FF_A5A5);

        axi_write(4'hC, 32'h1234_5678, 4'hF, 0, 5, 3, -1, resp, bf);
        checkOutput("split_bvalid_cycle", 32'(bf), 32'd6);
        checkOutput("split_bresp", 32'(resp), 32'd0);

        pulse_frames(5);
        axi_read(4'h8, 0, data, ac, rf);
        checkOutput("count_five", data, 32'd5);
        axi_write(4'h0, 32'h0000_0002, 4'hF, 0, 0, 0, 0, resp, bf);
        axi_read(4'h8, 0, data, ac, rf);
        checkOutput("count_cleared", data, 32'd0);
        axi_read(4'h0, 0, data, ac, rf);
        checkOutput("ctrl_after_clear", data, 32'd0);
        checkOutput("enable_after_clear", 32'(frame_enable), 32'd0);

        stop = 0;
        fork
            begin
                fork
                    for (int i = 0; i < 40; i++) begin
                        axi_write({2'($urandom_range(0, 3)), 2'($urandom)}, $urandom,
                                  ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                                  -1, resp, bf);
                    end
                    for (int j = 0; j < 40; j++) begin
                        logic [31:0] rd;
                        int a, r;
                        axi_read({2'($urandom_range(0, 3)), 2'($urandom)}, $urandom_range(0, 2), rd, a, r);
                    end
                join
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(negedge s00_axi_aclk);
                    #1;
                    frame_done = ($urandom_range(0, 2) == 0);
                end
                frame_done = 1'b0;
            end
        join

        axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, -1, resp, bf);
        axi_write(4'h4, 32'h1234, 4'hF, 0, 0, 0, -1, resp, bf);
        axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, -1, resp, bf);
        pulse_frames(3);

        // Buffer an AW with no W, then reset; a later lone W must not pair with the discarded AW.
        @(negedge s00_axi_aclk);
        #1;
        s00_axi_bready  = 1'b0;
        s00_axi_rready  = 1'b0;
        s00_axi_awvalid = 1'b1;
        s00_axi_awaddr  = 4'hC;
        @(negedge s00_axi_aclk);
        #1;
        s00_axi_awvalid = 1'b0;
        s00_axi_areset  = 1'b1;
        @(negedge s00_axi_aclk);
        #1;
        s00_axi_areset = 1'b0;
        checkOutput("rst_awready", 32'(s00_axi_awready), 32'd1);
        checkOutput("rst_wready", 32'(s00_axi_wready), 32'd1);
        checkOutput("rst_arready", 32'(s00_axi_arready), 32'd1);
        checkOutput("rst_bvalid", 32'(s00_axi_bvalid), 32'd0);
        checkOutput("rst_frame_enable", 32'(frame_enable), 32'd0);
        checkOutput("rst_frame_len", 32'(frame_len), 32'h0100);
        r_exp = '{32'h0, 32'h100, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            axi_read(r_addr[i], 0, data, ac, rf);
            checkOutput($sformatf("rst_read_%0d", i), data, r_exp[i]);
        end
        @(negedge s00_axi_aclk);
        #1;
        s00_axi_rready = 1'b0;
        s00_axi_wvalid = 1'b1;
        s00_axi_wdata  = 32'hCAFE_F00D;
        s00_axi_wstrb  = 4'hF;
        @(negedge s00_axi_aclk);
        #1;
        s00_axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge s00_axi_aclk);
            checkOutput("rst_no_bvalid", 32'(s00_axi_bvalid), 32'd0);
        end
    endtask

    initial begin
        s00_axi_areset  = 1'b1;
        s00_axi_awaddr  = '0;
        s00_axi_awprot  = '0;
        s00_axi_awvalid = 1'b0;
        s00_axi_wdata   = '0;
        s00_axi_wstrb   = '0;
        s00_axi_wvalid  = 1'b0;
        s00_axi_bready  = 1'b0;
        s00_axi_araddr  = '0;
        s00_axi_arprot  = '0;
        s00_axi_arvalid = 1'b0;
        s00_axi_rready  = 1'b0;
        frame_done      = 1'b0;
        repeat (2) @(posedge s00_axi_aclk);
        @(negedge s00_axi_aclk);
        checkOutput("reset_awready", 32'(s00_axi_awready), 32'd1);
        checkOutput("reset_bvalid", 32'(s00_axi_bvalid), 32'd0);
        checkOutput("reset_rdata", s00_axi_rdata, 32'd0);
        checkOutput("reset_frame_len", 32'(frame_len), 32'h0100);
        #1;
        s00_axi_areset = 1'b0;
        applyStimulus();
        repeat (2) @(posedge s00_axi_aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
